// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// datapath mux selects and the ALU operation codes produced by aludec.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Immediate format follows the opcode alone; R-type and unknown opcodes use I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:     imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps ALUOp plus the instruction funct fields to an ALU operation.
import mc_pkg::*;

module aludec (
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [3:0] ALUControl
);

  // Operation select; sub/sra only when instr[30] is a real funct7 bit.
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct7b5) ALUControl = ALU_SUB;
            else                 ALUControl = ALU_ADD;
          end
          3'b001: ALUControl = ALU_SLL;
          3'b010: ALUControl = ALU_SLT;
          3'b011: ALUControl = ALU_SLTU;
          3'b100: ALUControl = ALU_XOR;
          3'b101: begin
            if (funct7b5) ALUControl = ALU_SRA;
            else          ALUControl = ALU_SRL;
          end
          3'b110: ALUControl = ALU_OR;
          3'b111: ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory wait handshake and sticky illegal halt.
import mc_pkg::*;

module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal
);

  state_t     state_r;
  state_t     next_state_s;
  aluop_t     alu_op_s;
  logic       mem_req_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       reg_write_s;

  // State register; reset returns to FETCH and abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= FETCH;
    else          state_r <= next_state_s;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    next_state_s = state_r;
    alu_op_s     = ALUOP_ADD;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REGB;
    illegal      = 1'b0;
    case (state_r)
      FETCH: begin
        mem_req_s  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        if (mem_ready) next_state_s = DECODE;
        else           next_state_s = FETCH;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_RTYPE:     next_state_s = EXECUTER;
          OP_ITYPE:     next_state_s = EXECUTEI;
          OP_BRANCH:    next_state_s = BRANCH;
          OP_JAL:       next_state_s = JAL;
          default:      next_state_s = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        if (op == OP_LW) next_state_s = MEMREAD;
        else             next_state_s = MEMWRITE;
      end
      MEMREAD: begin
        mem_req_s = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) next_state_s = MEMWB;
        else           next_state_s = MEMREAD;
      end
      MEMWB: begin
        ResultSrc    = RES_DATA;
        reg_write_s  = 1'b1;
        next_state_s = FETCH;
      end
      MEMWRITE: begin
        mem_req_s   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready) next_state_s = FETCH;
        else           next_state_s = MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA      = SRCA_REGA;
        ALUSrcB      = SRCB_REGB;
        alu_op_s     = ALUOP_FUNCT;
        next_state_s = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA      = SRCA_REGA;
        ALUSrcB      = SRCB_IMM;
        alu_op_s     = ALUOP_FUNCT;
        next_state_s = ALUWB;
      end
      ALUWB: begin
        reg_write_s  = 1'b1;
        next_state_s = FETCH;
      end
      BRANCH: begin
        // funct3[0] distinguishes bne from beq.
        ALUSrcA      = SRCA_REGA;
        ALUSrcB      = SRCB_REGB;
        alu_op_s     = ALUOP_SUB;
        pc_write_s   = Zero ^ funct3[0];
        next_state_s = FETCH;
      end
      JAL: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_s   = 1'b1;
        next_state_s = ALUWB;
      end
      ILLEGAL: begin
        illegal      = 1'b1;
        next_state_s = ILLEGAL;
      end
      default: next_state_s = FETCH;
    endcase
  end

  // Strobes are held off while reset is asserted, even though FETCH is already showing.
  always_comb begin
    mem_req  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    if (reset_n) begin
      mem_req  = mem_req_s;
      MemWrite = mem_write_s;
      IRWrite  = ir_write_s;
      PCWrite  = pc_write_s;
      RegWrite = reg_write_s;
    end else begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign ImmSrc = imm_src_of(op);

  aludec u_aludec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_op     (alu_op_s),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is planned as a list of micro-steps and
// every cycle's outputs are checked against what that step must drive.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5;
  localparam int ST_ER = 6, ST_EI = 7, ST_AWB = 8, ST_BR = 9, ST_J = 10, ST_IL = 11;

  int vectors = 0;
  int miscompares = 0;
  int seq[$];
  int idx;
  bit done;
  bit rand_ready = 1'b0;
  int zero_force = -1;
  int hold_mw = 0;
  int hold_mr = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction lifetime as a list of micro-steps.
  function automatic void plan(input logic [6:0] o);
    seq.delete();
    seq.push_back(ST_F);
    seq.push_back(ST_D);
    case (o)
      7'b0000011: begin seq.push_back(ST_MA); seq.push_back(ST_MR); seq.push_back(ST_MWB); end
      7'b0100011: begin seq.push_back(ST_MA); seq.push_back(ST_MW); end
      7'b0110011: begin seq.push_back(ST_ER); seq.push_back(ST_AWB); end
      7'b0010011: begin seq.push_back(ST_EI); seq.push_back(ST_AWB); end
      7'b1100011: seq.push_back(ST_BR);
      7'b1101111: begin seq.push_back(ST_J); seq.push_back(ST_AWB); end
      default:    seq.push_back(ST_IL);
    endcase
  endfunction

  function automatic logic [3:0] alu_fn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (o[5] && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd6;
      3'd2: return 4'd5;
      3'd3: return 4'd9;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd8 : 4'd7;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [1:0] imm_fn(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'd1;
      7'b1100011: return 2'd2;
      7'b1101111: return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

  task automatic check_outputs();
    int s;
    logic e_req, e_adr, e_mw, e_ir, e_pc, e_rw, e_ill;
    logic [1:0] e_res, e_a, e_b;
    logic [3:0] e_alu;
    s = seq[idx];
    {e_req, e_adr, e_mw, e_ir, e_pc, e_rw, e_ill} = 7'b0;
    e_res = 2'd0; e_a = 2'd0; e_b = 2'd0; e_alu = 4'd0;
    case (s)
      ST_F:   begin e_req = 1'b1; e_b = 2'd2; e_res = 2'd2; e_ir = mem_ready; e_pc = mem_ready; end
      ST_D:   begin e_a = 2'd1; e_b = 2'd1; end
      ST_MA:  begin e_a = 2'd2; e_b = 2'd1; end
      ST_MR:  begin e_req = 1'b1; e_adr = 1'b1; end
      ST_MWB: begin e_res = 2'd1; e_rw = 1'b1; end
      ST_MW:  begin e_req = 1'b1; e_adr = 1'b1; e_mw = 1'b1; end
      ST_ER:  begin e_a = 2'd2; e_alu = alu_fn(op, funct3, funct7b5); end
      ST_EI:  begin e_a = 2'd2; e_b = 2'd1; e_alu = alu_fn(op, funct3, funct7b5); end
      ST_AWB: e_rw = 1'b1;
      ST_BR:  begin e_a = 2'd2; e_alu = 4'd1; e_pc = Zero ^ funct3[0]; end
      ST_J:   begin e_a = 2'd1; e_b = 2'd2; e_pc = 1'b1; end
      default: e_ill = 1'b1;
    endcase
    if (!reset_n) {e_req, e_mw, e_ir, e_pc, e_rw, e_ill} = 6'b0;
    check_val($sformatf("mem_req@%0d", s), {7'd0, mem_req}, {7'd0, e_req});
    check_val($sformatf("AdrSrc@%0d", s), {7'd0, AdrSrc}, {7'd0, e_adr});
    check_val($sformatf("MemWrite@%0d", s), {7'd0, MemWrite}, {7'd0, e_mw});
    check_val($sformatf("IRWrite@%0d", s), {7'd0, IRWrite}, {7'd0, e_ir});
    check_val($sformatf("PCWrite@%0d", s), {7'd0, PCWrite}, {7'd0, e_pc});
    check_val($sformatf("RegWrite@%0d", s), {7'd0, RegWrite}, {7'd0, e_rw});
    check_val($sformatf("illegal@%0d", s), {7'd0, illegal}, {7'd0, e_ill});
    check_val($sformatf("ResultSrc@%0d", s), {6'd0, ResultSrc}, {6'd0, e_res});
    check_val($sformatf("ALUSrcA@%0d", s), {6'd0, ALUSrcA}, {6'd0, e_a});
    check_val($sformatf("ALUSrcB@%0d", s), {6'd0, ALUSrcB}, {6'd0, e_b});
    check_val($sformatf("ALUControl@%0d", s), {4'd0, ALUControl}, {4'd0, e_alu});
    check_val($sformatf("ImmSrc@%0d", s), {6'd0, ImmSrc}, {6'd0, imm_fn(op)});
  endtask

  // One clock: drive at negedge, check mid-cycle, advance the model at posedge.
  task automatic cycle();
    int s;
    s = seq[idx];
    if (s == ST_MW && hold_mw > 0) begin
      mem_ready = 1'b0; hold_mw--;
    end else if (s == ST_MR && hold_mr > 0) begin
      mem_ready = 1'b0; hold_mr--;
    end else begin
      mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    Zero = (zero_force < 0) ? 1'($urandom_range(0, 1)) : zero_force[0];
    #2 check_outputs();
    @(posedge clk);
    if (reset_n && s != ST_IL) begin
      if (!((s == ST_F || s == ST_MR || s == ST_MW) && !mem_ready)) begin
        idx++;
        if (idx == seq.size()) done = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    idx = 0;
    done = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    reset_n = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    int il_cycles;
    int n;
    il_cycles = 0; n = 0;
    op = o; funct3 = f3; funct7b5 = f7;
    plan(o); idx = 0; done = 1'b0;
    while (!done && il_cycles < 10 && n < 60) begin
      cycle(); n++;
      if (!done && seq[idx] == ST_IL) il_cycles++;
    end
    if (n >= 60) check_val("cycle_budget", 8'd1, 8'd0);
    if (il_cycles >= 10) do_reset(2);
  endtask

  initial begin
    logic [6:0] ops [8];
    int n;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b0000000, 7'b1110011};
    reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; mem_ready = 1'b0;
    plan(op); idx = 0; done = 1'b0;
    @(negedge clk);
    do_reset(2);

    run_instr(7'b0000011, 3'd2, 1'b0);              // lw, always ready
    hold_mw = 2;
    run_instr(7'b0100011, 3'd2, 1'b0);              // sw, two wait cycles
    zero_force = 1;
    run_instr(7'b1100011, 3'd0, 1'b0);              // beq taken
    run_instr(7'b1100011, 3'd1, 1'b0);              // bne not taken
    zero_force = -1;
    run_instr(7'b0110011, 3'd0, 1'b1);              // sub
    run_instr(7'b1101111, 3'd0, 1'b0);              // jal
    run_instr(7'b0000000, 3'd0, 1'b0);              // illegal, hold then reset

    // Reset while stalled in the load data phase.
    hold_mr = 1000;
    op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
    plan(op); idx = 0; done = 1'b0;
    n = 0;
    while (seq[idx] != ST_MR && n < 20) begin cycle(); n++; end
    cycle(); cycle();
    do_reset(1);
    hold_mr = 0;
    run_instr(7'b0000011, 3'd2, 1'b0);

    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      run_instr(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core: it sequences a shared ALU, a unified instruction/data memory and the register file over several cycles per instruction. It replaces the single-cycle decode path and reuses the existing ALU decoder for `ALUControl`. It also adds a `mem_ready` wait handshake and a sticky illegal-instruction halt.

## Interface
Parameters: none.
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `op`  in  7  opcode from instruction register (valid from DECODE onward)
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `Zero`  in  1  ALU zero flag (combinational, same cycle)
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access requested
- `AdrSrc`  out  1  memory address: 0=PC, 1=Result
- `MemWrite`  out  1  store strobe
- `IRWrite`  out  1  latch instruction register and OldPC
- `PCWrite`  out  1  PC load enable
- `RegWrite`  out  1  register-file write
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `ALUSrcA`  out  2  00=PC, 01=OldPC, 10=rs1 reg A
- `ALUSrcB`  out  2  00=rs2 reg, 01=ImmExt, 10=constant 4
- `ImmSrc`  out  2  00=I, 01=S, 10=B, 11=J; decoded from `op`, 00 for all other opcodes
- `ALUControl`  out  4  ALU operation (aludec encoding)
- `illegal`  out  1  sticky halt flag

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111.
- ALUOp: 00=add, 01=sub, 10=funct-decoded. Feed it to aludec with `op[5]`, `funct3` and `funct7b5`.
- Unlisted outputs in a state are 0, except that `ALUSrcA`, `ALUSrcB` and `ResultSrc` default to 00.
- FETCH: `mem_req`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, ALUOp=00, `ResultSrc`=10.
  - `IRWrite`=`PCWrite`=`mem_ready`.
  - Go to DECODE on `mem_ready`; otherwise stay in FETCH.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, ALUOp=00 (branch target into ALUOut). Next state by `op`:
  - lw/sw → MEMADR
  - R → EXECUTER
  - I → EXECUTEI
  - branch → BRANCH
  - jal → JAL
  - any other → ILLEGAL
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, ALUOp=00. Next: MEMREAD if `op`=lw, else MEMWRITE.
- MEMREAD: `mem_req`=1, `AdrSrc`=1. Go to MEMWB on `mem_ready`; otherwise hold.
- MEMWB: `ResultSrc`=01, `RegWrite`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `AdrSrc`=1, `MemWrite`=1. Hold until `mem_ready`, then FETCH.
- EXECUTER: `ALUSrcA`=10, `ALUSrcB`=00, ALUOp=10, then ALUWB.
- EXECUTEI: `ALUSrcA`=10, `ALUSrcB`=01, ALUOp=10, then ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1, then FETCH.
- BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, ALUOp=01, `ResultSrc`=00.
  - `PCWrite` = `Zero` XOR `funct3[0]` (beq/bne).
  - Then FETCH.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, ALUOp=00, `ResultSrc`=00, `PCWrite`=1, then ALUWB (writes PC+4 to rd).
- ILLEGAL: absorbing state. `illegal`=1 and all strobes and `mem_req` are 0 until reset.

## Timing
- The state register is the only sequential element. All outputs are combinational from state plus inputs (Moore, except the `mem_ready`/`Zero` gating).
- Reset: `reset_n`=0 forces state to FETCH asynchronously. While `reset_n`=0, `mem_req`, `IRWrite`, `PCWrite`, `MemWrite`, `RegWrite` and `illegal` are 0. The remaining outputs take their FETCH values.
- Reset asserted mid-instruction abandons the instruction. No partial write occurs after the asserting edge.
- Minimum cycles (`mem_ready` always 1): lw 5, sw 4, R 4, I 4, branch 3, jal 4.
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds one cycle. `MemWrite` and `AdrSrc` stay stable throughout the wait.
- `mem_ready` is ignored in all other states.

## Structure
- Package `mc_pkg`:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, ILLEGAL)
  - opcode constants
  - ALUOp, `ResultSrc`, `ALUSrcA`/`ALUSrcB` and `ImmSrc` encodings
- Instantiate the existing `aludec` as the single sub-module. The FSM and `ImmSrc` decode live in this block.

## Test plan
- lw, `mem_ready`=1: states FETCH→DECODE→MEMADR→MEMREAD→MEMWB→FETCH. `RegWrite`=1 only in cycle 5, with `ResultSrc`=01.
- sw, `mem_ready` low for 2 cycles in MEMWRITE: `MemWrite`=1 for 3 cycles with `AdrSrc`=1. FETCH follows the ready cycle.
- Branch with `Zero`=1: `funct3`=000 gives `PCWrite`=1 in BRANCH; `funct3`=001 gives `PCWrite`=0.
- R-type with `funct3`=000, `funct7b5`=1: `ALUControl` equals the aludec SUB code in EXECUTER. ALUWB follows with `RegWrite`=1.
- `op`=0000000: DECODE→ILLEGAL with `illegal`=1. Hold 10 cycles with no strobes; `reset_n` pulse returns to FETCH with `illegal`=0.
- `reset_n` dropped during MEMREAD with `mem_ready`=0: strobes go to 0 immediately and state is FETCH; after release, FETCH issues `mem_req`=1 with `AdrSrc`=0.
